// File: rtl/alarm_trigger_if.sv
// Bundle of alarm settings, current time, user pulses and alarm status outputs.
// The master drives settings/time/user pulses; the slave (alarm_trigger) drives status.
interface alarm_trigger_if;
  logic       enable;
  logic [6:0] alarm_hour;
  logic [6:0] alarm_min;
  logic [6:0] time_hour;
  logic [6:0] time_min;
  logic       sec_tick;
  logic       dismiss;
  logic       snooze;
  logic       ringing;
  logic       buzzer;
  logic       snoozing;
  logic [1:0] snoozes_left;
  logic       missed;

  modport master (
    output enable, alarm_hour, alarm_min, time_hour, time_min,
           sec_tick, dismiss, snooze,
    input  ringing, buzzer, snoozing, snoozes_left, missed
  );

  modport slave (
    input  enable, alarm_hour, alarm_min, time_hour, time_min,
           sec_tick, dismiss, snooze,
    output ringing, buzzer, snoozing, snoozes_left, missed
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm clock trigger: rings on the rising edge of a time/alarm match, supports
// a limited number of snoozes, times out unattended rings and locks out re-rings.
module alarm_trigger #(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic           clk,
  input  logic           clear_n,
  alarm_trigger_if.slave bus
);

  localparam logic [8:0] RING_LIM   = 9'(RING_SEC);
  localparam logic [8:0] SNOOZE_LIM = 9'(SNOOZE_SEC);
  localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE, LOCKOUT} state_t;

  state_t     state, state_nxt;
  logic [8:0] sec_cnt, sec_cnt_nxt, sec_cnt_inc;
  logic [1:0] left, left_nxt;
  logic       buzz, buzz_nxt;
  logic       missed_q, missed_nxt;
  logic       match, match_d, trigger;

  assign match = bus.enable &&
                 (bus.alarm_hour != 7'd127) && (bus.alarm_min != 7'd127) &&
                 (bus.time_hour == bus.alarm_hour) && (bus.time_min == bus.alarm_min);
  assign trigger     = match & ~match_d;
  assign sec_cnt_inc = (sec_cnt == 9'd511) ? sec_cnt : sec_cnt + 9'd1;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      sec_cnt  <= 9'd0;
      left     <= 2'd0;
      buzz     <= 1'b0;
      missed_q <= 1'b0;
      match_d  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sec_cnt  <= sec_cnt_nxt;
      left     <= left_nxt;
      buzz     <= buzz_nxt;
      missed_q <= missed_nxt;
      match_d  <= match;
    end
  end

  // Branch order encodes the priority: enable, dismiss, snooze, expiry, counting.
  always_comb begin
    state_nxt   = state;
    sec_cnt_nxt = sec_cnt;
    left_nxt    = left;
    buzz_nxt    = buzz;
    missed_nxt  = 1'b0;
    if (!bus.enable) begin
      state_nxt   = IDLE;
      sec_cnt_nxt = 9'd0;
      buzz_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state_nxt   = RINGING;
            sec_cnt_nxt = 9'd0;
            left_nxt    = SNOOZE_MAX;
            buzz_nxt    = 1'b1;
          end
        end
        RINGING: begin
          if (bus.dismiss) begin
            state_nxt = LOCKOUT;
            buzz_nxt  = 1'b0;
          end else if (bus.snooze && (left != 2'd0)) begin
            state_nxt   = SNOOZE;
            left_nxt    = left - 2'd1;
            sec_cnt_nxt = 9'd0;
            buzz_nxt    = 1'b0;
          end else if (bus.sec_tick) begin
            sec_cnt_nxt = sec_cnt_inc;
            if (sec_cnt_inc == RING_LIM) begin
              state_nxt  = LOCKOUT;
              missed_nxt = 1'b1;
              buzz_nxt   = 1'b0;
            end else begin
              buzz_nxt = ~buzz;
            end
          end
        end
        SNOOZE: begin
          if (bus.dismiss) begin
            state_nxt = LOCKOUT;
          end else if (bus.sec_tick) begin
            sec_cnt_nxt = sec_cnt_inc;
            if (sec_cnt_inc == SNOOZE_LIM) begin
              state_nxt   = RINGING;
              sec_cnt_nxt = 9'd0;
              buzz_nxt    = 1'b1;
            end
          end
        end
        LOCKOUT: begin
          // Held here until the matched minute passes so the same minute cannot re-ring.
          if (!match) begin
            state_nxt   = IDLE;
            sec_cnt_nxt = 9'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.ringing      = (state == RINGING);
  assign bus.snoozing     = (state == SNOOZE);
  assign bus.buzzer       = buzz;
  assign bus.snoozes_left = left;
  assign bus.missed       = missed_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: directed scenarios against fixed expectations
// plus a randomized run compared to an event-level reference model.
module tb_alarm_trigger;

  localparam int SNOOZE_SEC = 12;
  localparam int RING_SEC   = 60;
  localparam int MAX_SNOOZE = 3;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;
  localparam int M_LOCK = 3;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         m_mode;
  int         m_ticks;
  logic [1:0] m_left;
  logic       m_missed;
  logic       m_prev;

  alarm_trigger_if bus();

  alarm_trigger #(.SNOOZE_SEC(SNOOZE_SEC), .RING_SEC(RING_SEC), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic bit model_match();
    return bus.enable && (bus.alarm_hour != 7'd127) && (bus.alarm_min != 7'd127) &&
           (bus.time_hour == bus.alarm_hour) && (bus.time_min == bus.alarm_min);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ticks = 0; m_left = 2'd0; m_missed = 1'b0; m_prev = 1'b0;
  endtask

  // Event-level view: ticks counted since the current ring/snooze phase began.
  task automatic model_edge();
    bit m;
    m = model_match();
    m_missed = 1'b0;
    if (!bus.enable) begin
      m_mode = M_IDLE; m_ticks = 0;
    end else if (m_mode == M_IDLE) begin
      if (m && !m_prev) begin m_mode = M_RING; m_ticks = 0; m_left = 2'(MAX_SNOOZE); end
    end else if (m_mode == M_RING) begin
      if (bus.dismiss) m_mode = M_LOCK;
      else if (bus.snooze && m_left > 0) begin m_mode = M_SNZ; m_left = m_left - 2'd1; m_ticks = 0; end
      else if (bus.sec_tick) begin
        m_ticks++;
        if (m_ticks == RING_SEC) begin m_mode = M_LOCK; m_missed = 1'b1; end
      end
    end else if (m_mode == M_SNZ) begin
      if (bus.dismiss) m_mode = M_LOCK;
      else if (bus.sec_tick) begin
        m_ticks++;
        if (m_ticks == SNOOZE_SEC) begin m_mode = M_RING; m_ticks = 0; end
      end
    end else if (!m) begin
      m_mode = M_IDLE;
    end
    m_prev = m;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!clear_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1; cycle(); bus.sec_tick = 1'b0;
  endtask

  task automatic start_ring();
    bus.enable = 1'b1; bus.alarm_hour = 7'd7; bus.alarm_min = 7'd30;
    bus.time_hour = 7'd7; bus.time_min = 7'd29;
    bus.sec_tick = 1'b0; bus.dismiss = 1'b0; bus.snooze = 1'b0;
    clear_n = 1'b0; #1; clear_n = 1'b1; model_reset();
    cycle();
    bus.time_min = 7'd30;
    cycle();
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.alarm_hour = 7'd7; bus.alarm_min = 7'd30;
    bus.time_hour = 7'd7; bus.time_min = 7'd30;
    bus.sec_tick = 1'b0; bus.dismiss = 1'b0; bus.snooze = 1'b0;
    clear_n = 1'b0; model_reset();
    repeat (2) cycle();
    checks++;
    if ({bus.ringing, bus.buzzer, bus.snoozing, bus.missed, bus.snoozes_left} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got r%b b%b s%b m%b left%0d want all 0",
               bus.ringing, bus.buzzer, bus.snoozing, bus.missed, bus.snoozes_left);
    end
    clear_n = 1'b1;
    cycle();
    checks++;
    if (bus.ringing !== 1'b1 || bus.snoozes_left !== 2'd3) begin
      errors++;
      $display("[TB] FAIL match_at_release got ringing=%b left=%0d want 1 3", bus.ringing, bus.snoozes_left);
    end
  endtask

  task automatic test_ring_timeout();
    int missed_cnt;
    start_ring();
    checks++;
    if (bus.ringing !== 1'b1 || bus.buzzer !== 1'b1 || bus.snoozes_left !== 2'd3) begin
      errors++;
      $display("[TB] FAIL ring_start got r%b b%b left%0d want 1 1 3", bus.ringing, bus.buzzer, bus.snoozes_left);
    end
    missed_cnt = 0;
    for (int i = 1; i <= RING_SEC; i++) begin
      tick();
      if (bus.missed === 1'b1) missed_cnt++;
      if (i < RING_SEC) begin
        checks++;
        if (bus.ringing !== 1'b1 || bus.buzzer !== ((i % 2) == 0)) begin
          errors++;
          $display("[TB] FAIL ring_buzz tick %0d got r%b b%b want 1 %0d", i, bus.ringing, bus.buzzer, (i % 2) == 0);
        end
      end else begin
        checks++;
        if (bus.missed !== 1'b1 || bus.ringing !== 1'b0 || bus.buzzer !== 1'b0) begin
          errors++;
          $display("[TB] FAIL timeout got m%b r%b b%b want 1 0 0", bus.missed, bus.ringing, bus.buzzer);
        end
      end
    end
    repeat (5) begin
      tick();
      if (bus.missed === 1'b1) missed_cnt++;
    end
    checks++;
    if (missed_cnt != 1 || bus.ringing !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lockout_hold got missed_pulses=%0d ringing=%b want 1 0", missed_cnt, bus.ringing);
    end
    bus.time_min = 7'd31; cycle();
    bus.time_min = 7'd30; cycle();
    checks++;
    if (bus.ringing !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rearm_after_minute got ringing=%b want 1", bus.ringing);
    end
  endtask

  task automatic test_snooze();
    start_ring();
    for (int n = 1; n <= 3; n++) begin
      bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
      checks++;
      if (bus.snoozing !== 1'b1 || bus.buzzer !== 1'b0 || bus.snoozes_left !== 2'(3 - n)) begin
        errors++;
        $display("[TB] FAIL snooze_%0d got s%b b%b left%0d want 1 0 %0d", n, bus.snoozing, bus.buzzer, bus.snoozes_left, 3 - n);
      end
      bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
      repeat (SNOOZE_SEC - 1) tick();
      checks++;
      if (bus.snoozing !== 1'b1 || bus.snoozes_left !== 2'(3 - n)) begin
        errors++;
        $display("[TB] FAIL snooze_hold_%0d got s%b left%0d want 1 %0d", n, bus.snoozing, bus.snoozes_left, 3 - n);
      end
      tick();
      checks++;
      if (bus.ringing !== 1'b1 || bus.buzzer !== 1'b1 || bus.snoozing !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rering_%0d got r%b b%b s%b want 1 1 0", n, bus.ringing, bus.buzzer, bus.snoozing);
      end
    end
    bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
    checks++;
    if (bus.ringing !== 1'b1 || bus.snoozing !== 1'b0 || bus.snoozes_left !== 2'd0) begin
      errors++;
      $display("[TB] FAIL fourth_snooze got r%b s%b left%0d want 1 0 0", bus.ringing, bus.snoozing, bus.snoozes_left);
    end
    bus.dismiss = 1'b1; cycle(); bus.dismiss = 1'b0;
    repeat (3) cycle();
    checks++;
    if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0 || bus.buzzer !== 1'b0 || bus.missed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dismiss_lockout got r%b s%b b%b m%b want 0 0 0 0", bus.ringing, bus.snoozing, bus.buzzer, bus.missed);
    end
  endtask

  task automatic test_unset_and_enable();
    start_ring();
    bus.enable = 1'b0; cycle();
    checks++;
    if (bus.ringing !== 1'b0 || bus.buzzer !== 1'b0 || bus.missed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_drop got r%b b%b m%b want 0 0 0", bus.ringing, bus.buzzer, bus.missed);
    end
    bus.enable = 1'b1; bus.alarm_min = 7'd127;
    bus.time_min = 7'd29; cycle();
    bus.time_min = 7'd30; cycle();
    bus.time_min = 7'd127; repeat (3) cycle();
    checks++;
    if (bus.ringing !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unset_min got ringing=%b want 0", bus.ringing);
    end
    bus.alarm_min = 7'd45; bus.time_min = 7'd30; cycle();
    bus.alarm_min = 7'd30; cycle();
    checks++;
    if (bus.ringing !== 1'b1) begin
      errors++;
      $display("[TB] FAIL setting_change got ringing=%b want 1", bus.ringing);
    end
  endtask

  task automatic test_back_to_back();
    start_ring();
    bus.dismiss = 1'b1; bus.snooze = 1'b1; cycle();
    bus.dismiss = 1'b0; bus.snooze = 1'b0;
    checks++;
    if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0 || bus.snoozes_left !== 2'd3) begin
      errors++;
      $display("[TB] FAIL dismiss_and_snooze got r%b s%b left%0d want 0 0 3", bus.ringing, bus.snoozing, bus.snoozes_left);
    end
    start_ring();
    bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
    tick();
    clear_n = 1'b0; #1;
    checks++;
    if ({bus.ringing, bus.buzzer, bus.snoozing, bus.missed, bus.snoozes_left} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_clear got r%b b%b s%b m%b left%0d want all 0",
               bus.ringing, bus.buzzer, bus.snoozing, bus.missed, bus.snoozes_left);
    end
    model_reset();
    #2 clear_n = 1'b1;
  endtask

  task automatic test_random();
    int bad;
    start_ring();
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.enable   = ($urandom_range(0, 63) != 0);
      bus.sec_tick = ($urandom_range(0, 1) == 1);
      bus.dismiss  = ($urandom_range(0, 59) == 0);
      bus.snooze   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) bus.time_min = 7'($urandom_range(29, 31));
      if ($urandom_range(0, 99) == 0) bus.alarm_min = ($urandom_range(0, 3) == 0) ? 7'd127 : 7'd30;
      cycle();
      checks++;
      if (bus.ringing !== (m_mode == M_RING) || bus.snoozing !== (m_mode == M_SNZ) ||
          bus.buzzer !== ((m_mode == M_RING) && (m_ticks % 2 == 0)) ||
          bus.snoozes_left !== m_left || bus.missed !== m_missed) begin
        errors++;
        if (bad < 10)
          $display("[TB] FAIL random cyc %0d got r%b s%b b%b left%0d m%b want r%b s%b b%b left%0d m%b", c,
                   bus.ringing, bus.snoozing, bus.buzzer, bus.snoozes_left, bus.missed,
                   m_mode == M_RING, m_mode == M_SNZ, (m_mode == M_RING) && (m_ticks % 2 == 0), m_left, m_missed);
        bad++;
      end
    end
    bus.sec_tick = 1'b0; bus.dismiss = 1'b0; bus.snooze = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_unset_and_enable();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
